alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Registered output stage that sits directly downstream of the ALU functional units (bitwise OR/AND/XOR, add/sub).
- Captures each unit's result and 4-bit status word, and holds them in a 2-entry skid buffer with valid/ready handshake toward the writeback stage.
- Maintains the architectural flag register (N/Z/C/V), updated only by ops that request it.
- Decouples ALU combinational paths from writeback timing; full throughput when the consumer never stalls.

Parameters:
- WIDTH, 16, datapath width of result; must match the ALU units feeding the stage.
- TAG_W, 4, width of the destination-register tag carried alongside each result.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- inValid  in  1  upstream result/status/tag valid this cycle.
- inReady  out  1  stage can accept; transfer when inValid && inReady.
- inResult  in  WIDTH  ALU result.
- inStatus  in  4  ALU statusOut; bit indices per ST_NEG, ST_ZERO, ST_CARRY, ST_OVERFLOW defines ([3]=N, [2]=Z, [1]=C, [0]=V).
- inTag  in  TAG_W  destination tag.
- inUpdFlags  in  1  accepted op writes flag register.
- clearFlags  in  1  zero the flag register.
- outValid  out  1  head entry valid.
- outReady  in  1  downstream accepts; transfer when outValid && outReady.
- outResult  out  WIDTH  head entry result.
- outStatus  out  4  head entry status (per-op, not the flag register).
- outTag  out  TAG_W  head entry tag.
- flags  out  4  architectural flag register, same bit order as inStatus.

Behaviour:
- Reset (sync, rst=1 at edge): state EMPTY; outValid=0, inReady=1, outResult/outStatus/outTag=0, flags=0, skid entry invalid. Reset overrides all same-cycle activity, including a handshake in progress.
- Storage: head register (drives out*) and skid register. inReady is a registered output: 1 exactly when the skid register is empty. There is no combinational path from outReady to inReady.
- States and transitions. Push = inValid&&inReady; Pop = outValid&&outReady.
  - EMPTY: Push -> head<=in, go ONE.
  - ONE: Push&&!Pop -> skid<=in, go FULL. Push&&Pop -> head<=in, stay ONE. !Push&&Pop -> go EMPTY. Otherwise hold.
  - FULL: inReady=0, so no Push. Pop -> head<=skid, go ONE. Otherwise hold.
- Latency: accepted input appears on out* the next cycle when the stage was EMPTY or in ONE with a Pop. Sustained throughput is 1/cycle while outReady=1.
- Stall: outputs are stable while outValid=1 && outReady=0. No entry is dropped or duplicated. Order is strictly FIFO.
- Flags:
  - On Push with inUpdFlags=1, flags<=inStatus in the cycle of acceptance, independent of downstream drain.
  - clearFlags=1 sets flags to 0, except when the same cycle has Push&&inUpdFlags; then flags<=inStatus (update wins).
  - With inUpdFlags=0, flags hold.
  - An input with inValid=1 but inReady=0 never touches flags.
- Width: data passes unmodified. No arithmetic is performed. Tag and status travel with their result.

Optional Feature:
- Macro: ALU_RESULT_STAGE_PERF_EN.
- Defined:
  - Adds outputs opCount[31:0] (increments on each Pop) and stallCount[31:0] (increments each cycle with outValid=1 && outReady=0).
  - Both counters wrap from 0xFFFFFFFF to 0.
  - Both clear on rst.
  - Both clear on input perfClear (1 bit); perfClear takes priority over increment.
- Not defined: those ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset with rst held 2 cycles during an active Push (inValid=1, inResult=16'h1234) -> after release outValid=0, inReady=1, flags=4'b0000, and nothing from that cycle is retained.
- Streaming with outReady=1 and inResult 16'h0001..16'h0008 pushed back to back -> outResult shows the same sequence one cycle later, inReady stays 1, no gaps.
- Backpressure with outReady=0 after two Pushes (16'hA5A5 tag 3, 16'h0F0F tag 7) -> state FULL, inReady=0 from the next cycle, outResult holds 16'hA5A5; releasing outReady gives 16'hA5A5 then 16'h0F0F with tags 3 then 7.
- Flags: Push inStatus=4'b0100, inUpdFlags=1 -> flags=4'b0100 next cycle. Push inStatus=4'b1000, inUpdFlags=0 -> flags stay 4'b0100. clearFlags=1 together with Push inStatus=4'b1001, inUpdFlags=1 -> flags=4'b1001. clearFlags alone -> flags=4'b0000.
- Simultaneous Push and Pop in ONE -> head replaced with the new entry, state stays ONE, inReady=1; no entry lost (checked by scoreboard over 1000 random valid/ready cycles).
- With ALU_RESULT_STAGE_PERF_EN: 5 Pops and 3 stall cycles -> opCount=5, stallCount=3. Preloading opCount=32'hFFFFFFFF then one Pop -> opCount=0.

Source files
------------

// File: rtl/alu_result_stage.sv
// ----------------------------------------------------------------------------
// alu_result_stage
//
// Registered output stage placed directly after the ALU functional units.
// Each accepted ALU result travels with its 4-bit status word and its
// destination tag through a 2-entry skid buffer (head + skid) toward the
// writeback stage using a valid/ready handshake. The stage also keeps the
// architectural N/Z/C/V flag register, which changes only for ops that
// request a flag update.
//
// Ports:
//   clk         - single clock, all state changes on the rising edge
//   rst         - synchronous, active-high reset
//   inValid     - upstream result/status/tag valid this cycle
//   inReady     - stage can accept (registered, 1 while the skid entry is free)
//   inResult    - ALU result (WIDTH bits)
//   inStatus    - ALU status word: [3]=N, [2]=Z, [1]=C, [0]=V
//   inTag       - destination register tag (TAG_W bits)
//   inUpdFlags  - the accepted op writes the flag register
//   clearFlags  - zero the flag register (a same-cycle flag update wins)
//   outValid    - head entry valid
//   outReady    - downstream accepts the head entry
//   outResult   - head entry result
//   outStatus   - head entry per-op status (not the flag register)
//   outTag      - head entry tag
//   flags       - architectural flag register, same bit order as inStatus
//
// Optional feature (macro ALU_RESULT_STAGE_PERF_EN):
//   perfClear   - clears both performance counters (wins over increment)
//   opCount     - number of entries handed to writeback, wraps at 2^32
//   stallCount  - cycles with outValid=1 and outReady=0, wraps at 2^32
// Without the macro these ports and counters do not exist.
// ----------------------------------------------------------------------------
module alu_result_stage #(
   parameter int WIDTH = 16,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inValid,
   output logic             inReady,
   input  logic [WIDTH-1:0] inResult,
   input  logic [3:0]       inStatus,
   input  logic [TAG_W-1:0] inTag,
   input  logic             inUpdFlags,
   input  logic             clearFlags,
   output logic             outValid,
   input  logic             outReady,
   output logic [WIDTH-1:0] outResult,
   output logic [3:0]       outStatus,
   output logic [TAG_W-1:0] outTag,
`ifdef ALU_RESULT_STAGE_PERF_EN
   input  logic             perfClear,
   output logic [31:0]      opCount,
   output logic [31:0]      stallCount,
`endif
   output logic [3:0]       flags
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   skid_result;
   logic [3:0]         skid_status;
   logic [TAG_W-1:0]   skid_tag;

   logic               push;
   logic               pop;

   // Handshakes are formed only from registered outputs and the partner's
   // valid/ready, so outReady never reaches inReady combinationally.
   assign push = inValid && inReady;
   assign pop  = outValid && outReady;

   // Skid-buffer control. The head register always drives the out* ports;
   // the skid register only fills when a new entry arrives while the head is
   // stalled, and inReady drops exactly while the skid register is occupied.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= EMPTY;
         outValid    <= 1'b0;
         inReady     <= 1'b1;
         outResult   <= '0;
         outStatus   <= '0;
         outTag      <= '0;
         skid_result <= '0;
         skid_status <= '0;
         skid_tag    <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (push) begin
                  outResult <= inResult;
                  outStatus <= inStatus;
                  outTag    <= inTag;
                  outValid  <= 1'b1;
                  state     <= ONE;
               end
            end
            ONE: begin
               if (push && !pop) begin
                  skid_result <= inResult;
                  skid_status <= inStatus;
                  skid_tag    <= inTag;
                  inReady     <= 1'b0;
                  state       <= FULL;
               end else if (push && pop) begin
                  // Head drains and refills in the same cycle: full throughput.
                  outResult <= inResult;
                  outStatus <= inStatus;
                  outTag    <= inTag;
               end else if (pop) begin
                  outValid <= 1'b0;
                  state    <= EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  outResult <= skid_result;
                  outStatus <= skid_status;
                  outTag    <= skid_tag;
                  inReady   <= 1'b1;
                  state     <= ONE;
               end
            end
            default: begin
               state    <= EMPTY;
               outValid <= 1'b0;
               inReady  <= 1'b1;
            end
         endcase
      end
   end

   // Architectural flags follow the op at acceptance time, not at writeback,
   // so a stalled consumer never delays flag visibility. An update from an
   // accepted op takes precedence over a same-cycle clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         flags <= 4'b0000;
      end else if (push && inUpdFlags) begin
         flags <= inStatus;
      end else if (clearFlags) begin
         flags <= 4'b0000;
      end
   end

`ifdef ALU_RESULT_STAGE_PERF_EN
   // Performance counters: completed transfers and stalled cycles. Both wrap
   // naturally through 32-bit addition; a clear request beats an increment.
   always_ff @(posedge clk) begin
      if (rst || perfClear) begin
         opCount    <= 32'd0;
         stallCount <= 32'd0;
      end else begin
         if (pop) begin
            opCount <= opCount + 32'd1;
         end
         if (outValid && !outReady) begin
            stallCount <= stallCount + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// ----------------------------------------------------------------------------
// tb_alu_result_stage
//
// Self-checking bench for alu_result_stage. Stimulus is issued one cycle at a
// time; every accepted input is pushed into an expected-output queue and a
// separate monitor pops and compares whenever the stage hands an entry to
// writeback. The reference model tracks buffer occupancy, the flag register
// and (with ALU_RESULT_STAGE_PERF_EN) the performance counters as plain
// counts and values.
// ----------------------------------------------------------------------------
module tb_alu_result_stage;

   localparam int WIDTH = 16;
   localparam int TAG_W = 4;

   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic [3:0]       status;
      logic [TAG_W-1:0] tag;
   } entry_t;

   logic             clk;
   logic             rst;
   logic             inValid;
   logic             inReady;
   logic [WIDTH-1:0] inResult;
   logic [3:0]       inStatus;
   logic [TAG_W-1:0] inTag;
   logic             inUpdFlags;
   logic             clearFlags;
   logic             outValid;
   logic             outReady;
   logic [WIDTH-1:0] outResult;
   logic [3:0]       outStatus;
   logic [TAG_W-1:0] outTag;
   logic [3:0]       flags;
`ifdef ALU_RESULT_STAGE_PERF_EN
   logic             perfClear;
   logic [31:0]      opCount;
   logic [31:0]      stallCount;
   int unsigned      opModel;
   int unsigned      stallModel;
`endif

   entry_t           expQ[$];
   int               occ;
   logic [3:0]       flagModel;
   int               compared;
   int               mismatched;
   bit               monitorOn;

   alu_result_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .inValid    (inValid),
      .inReady    (inReady),
      .inResult   (inResult),
      .inStatus   (inStatus),
      .inTag      (inTag),
      .inUpdFlags (inUpdFlags),
      .clearFlags (clearFlags),
      .outValid   (outValid),
      .outReady   (outReady),
      .outResult  (outResult),
      .outStatus  (outStatus),
      .outTag     (outTag),
`ifdef ALU_RESULT_STAGE_PERF_EN
      .perfClear  (perfClear),
      .opCount    (opCount),
      .stallCount (stallCount),
`endif
      .flags      (flags)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: counts it, reports a FAIL line on disagreement.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h at time %0t", name, actual, expected, $time);
      end
   endtask

   // Drives one cycle of stimulus (called just after a rising edge), predicts
   // what the stage must accept and deliver, then advances past the next edge
   // and checks the flag register and counters.
   task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] r, input logic [3:0] s,
                                input logic [TAG_W-1:0] t, input logic upd, input logic clr,
                                input logic ordy);
      bit doPush;
      bit doPop;
      entry_t e;
      inValid    = v;
      inResult   = r;
      inStatus   = s;
      inTag      = t;
      inUpdFlags = upd;
      clearFlags = clr;
      outReady   = ordy;
      checkOutput("inReady", {31'd0, inReady}, {31'd0, (occ < 2)});
      checkOutput("outValid", {31'd0, outValid}, {31'd0, (occ > 0)});
      doPush = v && (occ < 2);
      doPop  = ordy && (occ > 0);
      if (doPush) begin
         e.result = r;
         e.status = s;
         e.tag    = t;
         expQ.push_back(e);
         if (upd) flagModel = s;
         else if (clr) flagModel = 4'b0000;
      end else if (clr) begin
         flagModel = 4'b0000;
      end
`ifdef ALU_RESULT_STAGE_PERF_EN
      if (doPop) opModel++;
      if (occ > 0 && !ordy) stallModel++;
`endif
      @(posedge clk);
      #1;
      occ = occ + int'(doPush) - int'(doPop);
      checkOutput("flags", {28'd0, flags}, {28'd0, flagModel});
`ifdef ALU_RESULT_STAGE_PERF_EN
      checkOutput("opCount", opCount, opModel);
      checkOutput("stallCount", stallCount, stallModel);
`endif
   endtask

   // Scoreboard monitor: just before the edge that completes a transfer,
   // compare the presented head entry with the oldest expected entry.
   always @(negedge clk) begin
      if (monitorOn && outValid === 1'b1 && outReady === 1'b1) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpectedOutput", {16'd0, outResult}, 32'hFFFF_FFFF);
         end else begin
            entry_t e;
            e = expQ.pop_front();
            checkOutput("outResult", {16'd0, outResult}, {16'd0, e.result});
            checkOutput("outStatus", {28'd0, outStatus}, {28'd0, e.status});
            checkOutput("outTag", {28'd0, outTag}, {28'd0, e.tag});
         end
      end
   end

   initial begin
      compared   = 0;
      mismatched = 0;
      monitorOn  = 1'b0;
      occ        = 0;
      flagModel  = 4'b0000;
`ifdef ALU_RESULT_STAGE_PERF_EN
      perfClear  = 1'b0;
      opModel    = 0;
      stallModel = 0;
`endif

      // Reset held for two edges while a push is being offered.
      rst        = 1'b1;
      inValid    = 1'b1;
      inResult   = 16'h1234;
      inStatus   = 4'b1111;
      inTag      = 4'hF;
      inUpdFlags = 1'b1;
      clearFlags = 1'b0;
      outReady   = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      inValid   = 1'b0;
      checkOutput("resetOutValid", {31'd0, outValid}, 32'd0);
      checkOutput("resetInReady", {31'd0, inReady}, 32'd1);
      checkOutput("resetFlags", {28'd0, flags}, 32'd0);
      checkOutput("resetOutResult", {16'd0, outResult}, 32'd0);
      monitorOn = 1'b1;

      // Back-to-back streaming with a consumer that never stalls.
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b1, WIDTH'(i), 4'b0000, TAG_W'(i), 1'b0, 1'b0, 1'b1);
         checkOutput("streamHead", {16'd0, outResult}, i);
      end
      applyStimulus(1'b0, 16'h0000, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b1);

      // Backpressure: two entries fill head and skid, then drain in order.
      applyStimulus(1'b1, 16'hA5A5, 4'b0000, 4'd3, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h0F0F, 4'b0000, 4'd7, 1'b0, 1'b0, 1'b0);
      checkOutput("fullInReady", {31'd0, inReady}, 32'd0);
      applyStimulus(1'b1, 16'hDEAD, 4'b0000, 4'd9, 1'b0, 1'b0, 1'b0);
      checkOutput("stallHead", {16'd0, outResult}, 32'h0000_A5A5);
      checkOutput("stallTag", {28'd0, outTag}, 32'd3);
      applyStimulus(1'b0, 16'h0000, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b1);
      checkOutput("drainSecond", {16'd0, outResult}, 32'h0000_0F0F);
      applyStimulus(1'b0, 16'h0000, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b1);

      // Flag register behaviour.
      applyStimulus(1'b1, 16'h0000, 4'b0100, 4'd1, 1'b1, 1'b0, 1'b1);
      checkOutput("flagsSet", {28'd0, flags}, 32'h4);
      applyStimulus(1'b1, 16'h8000, 4'b1000, 4'd2, 1'b0, 1'b0, 1'b1);
      checkOutput("flagsHold", {28'd0, flags}, 32'h4);
      applyStimulus(1'b1, 16'h8001, 4'b1001, 4'd3, 1'b1, 1'b1, 1'b1);
      checkOutput("flagsUpdateWins", {28'd0, flags}, 32'h9);
      applyStimulus(1'b0, 16'h0000, 4'b0000, 4'h0, 1'b0, 1'b1, 1'b1);
      checkOutput("flagsClear", {28'd0, flags}, 32'h0);

      // A refused input (stage full) must not touch flags.
      applyStimulus(1'b1, 16'h1111, 4'b0010, 4'd4, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h2222, 4'b0010, 4'd5, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h3333, 4'b1110, 4'd6, 1'b1, 1'b0, 1'b0);
      checkOutput("flagsRefused", {28'd0, flags}, 32'h0);
      applyStimulus(1'b0, 16'h0000, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 16'h0000, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b1);

      // Random valid/ready traffic against the queue model.
      for (int i = 0; i < 1000; i++) begin
         applyStimulus(1'($urandom_range(0, 3) != 0), WIDTH'($urandom), 4'($urandom),
                       TAG_W'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0),
                       1'($urandom_range(0, 3) != 0));
      end

      // Drain whatever is left and confirm nothing is outstanding.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 16'h0000, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b1);
      end
      checkOutput("drained", expQ.size(), 32'd0);

`ifdef ALU_RESULT_STAGE_PERF_EN
      perfClear = 1'b1;
      opModel    = 0;
      stallModel = 0;
      @(posedge clk);
      #1;
      perfClear = 1'b0;
      checkOutput("perfClearOps", opCount, 32'd0);
      checkOutput("perfClearStalls", stallCount, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
